mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU byte-addressed port and a 32-bit word memory.
// Sub-word stores use a read-modify-write; loads are lane-extracted and extended.
module mem_access_unit #(
    parameter int ADDR_W = 7
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_unsigned,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_misaligned,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_ERR
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    state_t            state;
    logic              we_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merged_q;
    logic              req_misaligned;

    // Size 11 behaves as word, so only size[1] marks a word access.
    assign req_misaligned = ((cpu_size == SZ_HALF) && cpu_addr[0]) ||
                            (cpu_size[1] && (cpu_addr[1:0] != 2'b00));

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: load_extract = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: load_extract = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_extract = word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                                input logic [15:0] data,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size);
        logic [31:0] r;
        r = old_word;
        if (size == SZ_BYTE)
            r[{lane, 3'b000} +: 8] = data[7:0];
        else
            r[{lane[1], 4'b0000} +: 16] = data;
        store_merge = r;
    endfunction

    // Strobes and handshakes are pure state decodes; the write strobe is also
    // qualified by the latched direction so a load can never emit a write.
    assign cpu_ready      = (state == S_IDLE);
    assign cpu_misaligned = (state == S_ERR);
    assign mem_read       = (state == S_LOAD) || (state == S_RMW_RD);
    assign mem_write      = we_q && ((state == S_STORE) || (state == S_RMW_WR));
    assign mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata      = (state == S_STORE) ? wdata_q : merged_q;

    // NOTE: every register here, including the latched request, is cleared by
    // the async reset so an aborted access leaves nothing behind to replay.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'b0;
            merged_q   <= 32'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= 32'b0;
        end else begin
            // NOTE: non-blocking assignments keep all next-state values based
            // on this cycle's register contents regardless of statement order.
            cpu_rvalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        we_q       <= cpu_we;
                        size_q     <= cpu_size;
                        unsigned_q <= cpu_unsigned;
                        addr_q     <= cpu_addr;
                        wdata_q    <= cpu_wdata;
                        if (req_misaligned)
                            state <= S_ERR;
                        else if (!cpu_we)
                            state <= S_LOAD;
                        else if (cpu_size[1])
                            state <= S_STORE;
                        else
                            state <= S_RMW_RD;
                    end
                end
                S_LOAD: begin
                    cpu_rdata  <= load_extract(mem_rdata, addr_q[1:0], size_q, unsigned_q);
                    cpu_rvalid <= 1'b1;
                    state      <= S_IDLE;
                end
                S_RMW_RD: begin
                    merged_q <= store_merge(mem_rdata, wdata_q[15:0], addr_q[1:0], size_q);
                    state    <= S_RMW_WR;
                end
                S_STORE, S_RMW_WR, S_ERR: state <= S_IDLE;
                default:                  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small word memory
// that updates read data on the falling edge and captures writes on the rising edge.
module tb_mem_access_unit;

    localparam int ADDR_W = 7;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [1:0]        cpu_size = 2'b00;
    logic              cpu_unsigned = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [31:0]       cpu_wdata = 32'b0;
    logic              cpu_ready;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;
    logic              cpu_misaligned;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'b0;

    logic [31:0] mem [0:31];
    logic        pl_en = 1'b0;
    logic [4:0]  pl_idx = 5'd0;
    logic [31:0] pl_data = 32'b0;

    int checks = 0;
    int errors = 0;
    int read_cnt = 0;
    int write_cnt = 0;
    int both_cnt = 0;

    always #5 clock = ~clock;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_size       (cpu_size),
        .cpu_unsigned   (cpu_unsigned),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_ready      (cpu_ready),
        .cpu_rvalid     (cpu_rvalid),
        .cpu_rdata      (cpu_rdata),
        .cpu_misaligned (cpu_misaligned),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    always @(posedge clock) begin
        if (pl_en)
            mem[pl_idx] <= pl_data;
        else if (mem_write)
            mem[mem_address[6:2]] <= mem_wdata;
        if (mem_read) read_cnt++;
        if (mem_write) write_cnt++;
        if (mem_read && mem_write) both_cnt++;
    end

    always @(negedge clock) begin
        if (mem_read) mem_rdata <= mem[mem_address[6:2]];
    end

    task automatic preload(input logic [4:0] idx, input logic [31:0] data);
        @(negedge clock);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    // Presents a request on a falling edge and returns #1 after the accepting rising edge.
    task automatic start(input logic we, input logic [1:0] size, input logic uns,
                         input logic [6:0] addr, input logic [31:0] wdata);
        int waited;
        @(negedge clock);
        cpu_we = we; cpu_size = size; cpu_unsigned = uns; cpu_addr = addr; cpu_wdata = wdata;
        cpu_req = 1'b1;
        waited = 0;
        while (!cpu_ready && waited < 8) begin
            @(negedge clock);
            waited++;
        end
        checks++;
        if (cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready addr=%h: cpu_ready=%b required 1", addr, cpu_ready);
        end
        @(posedge clock);
        #1 cpu_req = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({cpu_ready, cpu_rvalid, cpu_misaligned, mem_read, mem_write} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: ready/rvalid/mis/rd/wr=%b required 10000",
                     {cpu_ready, cpu_rvalid, cpu_misaligned, mem_read, mem_write});
        end
        checks++;
        if (cpu_rdata !== 32'h0 || mem_wdata !== 32'h0 || mem_address !== 7'h0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h wdata=%h addr=%h required zeros",
                     cpu_rdata, mem_wdata, mem_address);
        end
        preload(5'd2, 32'h12345678);
        // Request held during reset must not be accepted.
        @(negedge clock);
        cpu_we = 1'b0; cpu_size = 2'b10; cpu_unsigned = 1'b0; cpu_addr = 7'h08; cpu_req = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (mem_read !== 1'b0 || read_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_accept: mem_read=%b reads=%0d required 0 0", mem_read, read_cnt);
        end
        reset_n = 1'b1;
        @(posedge clock);
        #1 cpu_req = 1'b0;
        @(negedge clock);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 7'h08) begin
            errors++;
            $display("FAIL reset_first_accept: mem_read=%b addr=%h required 1 08", mem_read, mem_address);
        end
        @(negedge clock);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL lw_08: rvalid=%b rdata=%h required 1 12345678", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_load(input string name, input logic [1:0] size, input logic uns,
                             input logic [6:0] addr, input logic [31:0] exp);
        int r0;
        start(1'b0, size, uns, addr, 32'h0);
        r0 = read_cnt;
        @(negedge clock);
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || cpu_rvalid !== 1'b0 ||
            mem_address !== {addr[6:2], 2'b00}) begin
            errors++;
            $display("FAIL %s_strobe: rd=%b wr=%b rvalid=%b addr=%h required 1 0 0 %h",
                     name, mem_read, mem_write, cpu_rvalid, mem_address, {addr[6:2], 2'b00});
        end
        @(negedge clock);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp || mem_read !== 1'b0 ||
            cpu_ready !== 1'b1 || read_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL %s: rvalid=%b rdata=%h rd=%b ready=%b reads=%0d required 1 %h 0 1 1",
                     name, cpu_rvalid, cpu_rdata, mem_read, cpu_ready, read_cnt - r0, exp);
        end
    endtask

    task automatic test_store(input string name, input logic [1:0] size, input logic [6:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_word);
        int w0;
        w0 = write_cnt;
        start(1'b1, size, 1'b0, addr, wdata);
        if (size != 2'b10) begin
            @(negedge clock);
            checks++;
            if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
                errors++;
                $display("FAIL %s_rmw_rd: rd=%b wr=%b required 1 0", name, mem_read, mem_write);
            end
        end
        @(negedge clock);
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== exp_word ||
            mem_address !== {addr[6:2], 2'b00}) begin
            errors++;
            $display("FAIL %s_write: wr=%b rd=%b wdata=%h addr=%h required 1 0 %h %h",
                     name, mem_write, mem_read, mem_wdata, mem_address, exp_word, {addr[6:2], 2'b00});
        end
        @(negedge clock);
        checks++;
        if (cpu_ready !== 1'b1 || write_cnt - w0 !== 1 || mem[addr[6:2]] !== exp_word) begin
            errors++;
            $display("FAIL %s_done: ready=%b writes=%0d mem=%h required 1 1 %h",
                     name, cpu_ready, write_cnt - w0, mem[addr[6:2]], exp_word);
        end
    endtask

    task automatic test_misaligned(input string name, input logic we, input logic [1:0] size,
                                   input logic [6:0] addr);
        int r0;
        int w0;
        r0 = read_cnt;
        w0 = write_cnt;
        start(we, size, 1'b0, addr, 32'hDEADBEEF);
        @(negedge clock);
        checks++;
        if (cpu_misaligned !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL %s_err: mis=%b rd=%b wr=%b required 1 0 0",
                     name, cpu_misaligned, mem_read, mem_write);
        end
        @(negedge clock);
        checks++;
        if (cpu_misaligned !== 1'b0 || cpu_ready !== 1'b1 || read_cnt !== r0 ||
            write_cnt !== w0 || mem[2] !== 32'h12345678) begin
            errors++;
            $display("FAIL %s_after: mis=%b ready=%b reads=%0d writes=%0d mem=%h required 0 1 0 0 12345678",
                     name, cpu_misaligned, cpu_ready, read_cnt - r0, write_cnt - w0, mem[2]);
        end
    endtask

    task automatic test_reset_abort;
        int w0;
        preload(5'd2, 32'h12345678);
        w0 = write_cnt;
        start(1'b1, 2'b00, 1'b0, 7'h09, 32'h000000AB);
        @(negedge clock);
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_rmw_rd: mem_read=%b required 1", mem_read);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({cpu_ready, cpu_rvalid, cpu_misaligned, mem_read, mem_write} !== 5'b10000 ||
            cpu_rdata !== 32'h0 || mem_wdata !== 32'h0 || mem_address !== 7'h0) begin
            errors++;
            $display("FAIL abort_reset_vals: flags=%b rdata=%h wdata=%h addr=%h required 10000 0 0 0",
                     {cpu_ready, cpu_rvalid, cpu_misaligned, mem_read, mem_write},
                     cpu_rdata, mem_wdata, mem_address);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (write_cnt !== w0 || mem[2] !== 32'h12345678 || cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_write: writes=%0d mem=%h ready=%b required 0 12345678 1",
                     write_cnt - w0, mem[2], cpu_ready);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clock);
        cpu_we = 1'b0; cpu_size = 2'b10; cpu_unsigned = 1'b0; cpu_addr = 7'h08; cpu_req = 1'b1;
        @(posedge clock);
        #1 cpu_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678 || cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_load: rvalid=%b rdata=%h ready=%b required 1 12345678 1",
                     cpu_rvalid, cpu_rdata, cpu_ready);
        end
        cpu_we = 1'b1; cpu_size = 2'b10; cpu_addr = 7'h0C; cpu_wdata = 32'hCAFEF00D; cpu_req = 1'b1;
        @(posedge clock);
        #1 cpu_req = 1'b0;
        @(negedge clock);
        checks++;
        if (mem_write !== 1'b1 || mem_wdata !== 32'hCAFEF00D || mem_address !== 7'h0C ||
            cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL b2b_store: wr=%b wdata=%h addr=%h rvalid=%b rdata=%h required 1 cafef00d 0c 0 12345678",
                     mem_write, mem_wdata, mem_address, cpu_rvalid, cpu_rdata);
        end
        @(negedge clock);
        checks++;
        if (mem[3] !== 32'hCAFEF00D || cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_mem: mem=%h ready=%b required cafef00d 1", mem[3], cpu_ready);
        end
    endtask

    initial begin
        test_reset;
        preload(5'd2, 32'h80F45678);
        test_load("lh_0a", 2'b01, 1'b0, 7'h0A, 32'hFFFF80F4);
        test_load("lhu_0a", 2'b01, 1'b1, 7'h0A, 32'h000080F4);
        test_load("lb_0b", 2'b00, 1'b0, 7'h0B, 32'hFFFFFF80);
        test_load("lbu_08", 2'b00, 1'b1, 7'h08, 32'h00000078);
        test_load("lw_sz11", 2'b11, 1'b1, 7'h08, 32'h80F45678);
        preload(5'd2, 32'h12345678);
        test_store("sb_09", 2'b00, 7'h09, 32'h000000AB, 32'h1234AB78);
        test_store("sh_0a", 2'b01, 7'h0A, 32'h0000BEEF, 32'hBEEFAB78);
        test_store("sw_10", 2'b10, 7'h10, 32'hA5A55A5A, 32'hA5A55A5A);
        preload(5'd2, 32'h12345678);
        test_misaligned("sw_0a", 1'b1, 2'b10, 7'h0A);
        test_misaligned("lh_09", 1'b0, 2'b01, 7'h09);
        test_load("lw_rdata", 2'b10, 1'b0, 7'h08, 32'h12345678);
        test_reset_abort;
        test_back_to_back;
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL rd_wr_overlap: cycles=%0d required 0", both_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
